// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared parameters, state enum and 32-tap lowpass table for the FIR blocks
package fir_pkg;
  localparam int NTAPS = 32;
  localparam int L     = 2;
  localparam int TPP   = NTAPS / L;
  localparam int DW    = 16;
  localparam int CW    = 11;
  localparam int AW    = 32;
  localparam int PRW   = DW + CW;
  localparam int IW    = $clog2(NTAPS);
  localparam int KW    = $clog2(TPP);
  localparam int PW    = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  localparam logic signed [CW-1:0] H_HALF [TPP] = '{
    -11'sd17, -11'sd20, -11'sd26, -11'sd31, -11'sd29, -11'sd15, 11'sd20, 11'sd82,
    11'sd174, 11'sd294, 11'sd437, 11'sd591, 11'sd741, 11'sd873, 11'sd971, 11'sd1023
  };

  // Symmetric prototype: upper half mirrors the stored lower half.
  function automatic logic signed [CW-1:0] h_at(input logic [IW-1:0] idx);
    if (idx < IW'(TPP)) return H_HALF[idx[KW-1:0]];
    else return H_HALF[KW'(TPP - 1) - idx[KW-1:0]];
  endfunction
endpackage

// File: rtl/fir_coef_rom.sv
// rtl/fir_coef_rom.sv - combinational coefficient lookup, index = phase + L*k
module fir_coef_rom
  import fir_pkg::*;
(
  input  logic [IW-1:0]        idx,
  output logic signed [CW-1:0] coef
);
  always_comb coef = h_at(idx);
endmodule

// File: rtl/fir_interp2_polyphase.sv
// rtl/fir_interp2_polyphase.sv - 2x polyphase interpolating FIR, one shared MAC
module fir_interp2_polyphase
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [AW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  state_e              state_q, state_d;
  logic signed [DW-1:0] dl_q [TPP];
  logic signed [DW-1:0] dl_d [TPP];
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 live_q, live_d;

  logic signed [CW-1:0]  coef;
  logic signed [PRW-1:0] prod;
  logic signed [AW-1:0]  mac_sum;

  // L is a power of two, so phase + L*k is a plain concatenation.
  fir_coef_rom u_rom (
    .idx  ({k_q, phase_q}),
    .coef (coef)
  );

  always_comb begin
    prod    = dl_q[k_q] * coef;
    mac_sum = acc_q + {{(AW - PRW){prod[PRW-1]}}, prod};
  end

  // in_ready stays low through reset and rises on the first edge after release.
  assign in_ready  = live_q && (state_q == IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    dl_d        = dl_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    phase_d     = phase_q;
    k_d         = k_q;
    live_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 1; i < TPP; i++) dl_d[i] = dl_q[i-1];
          dl_d[0] = in_data;
          phase_d = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = mac_sum;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(TPP - 1)) begin
          out_data_d  = mac_sum;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (phase_q != PW'(L - 1)) begin
            phase_d = phase_q + PW'(1);
            k_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < TPP; i++) dl_q[i] <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      phase_q     <= '0;
      k_q         <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      phase_q     <= phase_d;
      k_q         <= k_d;
      live_q      <= live_d;
    end
  end
endmodule

// File: tb/tb_fir_interp2_polyphase.sv
// tb/tb_fir_interp2_polyphase.sv - scoreboard bench for fir_interp2_polyphase
module tb_fir_interp2_polyphase;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic signed [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  fir_interp2_polyphase dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int rise_exp = -1;
  int hs_cnt = 0;
  int h_tab [32];
  int hist [16];
  int exp_q [$];
  int out_log [$];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: y[2n+p] = sum_k h[p+2k] * x[n-k]
  task automatic model_push(input int x);
    int y0, y1;
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    y0 = 0;
    y1 = 0;
    for (int k = 0; k < 16; k++) begin
      y0 += hist[k] * h_tab[2*k];
      y1 += hist[k] * h_tab[2*k+1];
    end
    exp_q.push_back(y0);
    exp_q.push_back(y1);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) hist[k] = 0;
    exp_q.delete();
    hs_cnt = 0;
  endtask

  // Monitor: drives out_ready, checks stall stability, latency and scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, $signed(prev_data));
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && !prev_valid) chk("valid_latency", cyc, rise_exp);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %0d, required no output", out_data);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %0d, required %0d", out_data, e);
          end
        end
        out_log.push_back(int'(out_data));
        hs_cnt++;
        if (hs_cnt % 2 == 1) rise_exp = cyc + 17;
      end
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_ready = out_ready;
    end
  end

  task automatic send(input int x, input int hold);
    int n;
    n = 0;
    in_data  = 16'(x);
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0, required 1");
      in_valid = 1'b0;
      return;
    end
    model_push(x);
    rise_exp = cyc + 17;
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", in_ready, 0);
      in_data = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int h_half [16] = '{-17, -20, -26, -31, -29, -15, 20, 82,
                        174, 294, 437, 591, 741, 873, 971, 1023};
    int n0, n;
    for (int i = 0; i < 32; i++) h_tab[i] = (i < 16) ? h_half[i] : h_half[31 - i];
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Impulse response
    rdy_mode = 0;
    out_log.delete();
    send(1, 0);
    for (int i = 0; i < 17; i++) send(0, 0);
    drain();
    chk("imp_count", out_log.size(), 36);
    chk("imp_h0", out_log[0], -17);
    chk("imp_h15", out_log[15], 1023);
    chk("imp_h31", out_log[31], -17);
    chk("imp_tail", out_log[32], 0);

    // DC with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) send(1000, 0);
    drain();
    chk("dc_settled", out_log[out_log.size()-1], 5068000);
    chk("dc_settled_p0", out_log[out_log.size()-2], 5068000);

    // Full-scale negative
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) send(-32768, 0);
    drain();
    chk("fs_settled", out_log[out_log.size()-1], -166068224);
    chk("fs_settled_p0", out_log[out_log.size()-2], -166068224);

    // Backpressure held for 10 cycles in OUT
    rdy_mode = 2;
    n0 = out_log.size();
    send(int'($urandom_range(0, 65535)) - 32768, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    drain();
    chk("bp_transfers", out_log.size() - n0, 2);

    // in_valid held high through MAC/OUT
    send(12345, 20);
    drain();

    // Random samples, random out_ready
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 65535)) - 32768, 0);
    drain();

    // Reset while k==7 of the MAC
    rdy_mode = 0;
    send(-20000, 0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", in_ready, 1);
    out_log.delete();
    send(1, 0);
    for (int i = 0; i < 3; i++) send(0, 0);
    drain();
    chk("midrst_h0", out_log[0], -17);
    chk("midrst_h1", out_log[1], -20);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
